// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch <-> decode bus: instruction delivery and redirect back to fetch
interface decode_stage_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output valid, instr, pc,
        input  redirect, redirect_pc
    );

    modport slave (
        input  valid, instr, pc,
        output redirect, redirect_pc
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID register, 2R1W regfile with bypass, operand forwarding, branch resolution
// Optional macro DECODE_DELAY_SLOT_EN: MIPS delay slot (no wrong-path squash, link = pc+8).
module decode_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    localparam int FSEL_W = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    decode_stage_if.slave             fetch_if,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      wb_we_i,
    input  logic [REG_AW-1:0]         wb_addr_i,
    input  logic [DATA_W-1:0]         wb_data_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
    input  logic [FSEL_W-1:0]         fwd_sel_rs_i,
    input  logic [FSEL_W-1:0]         fwd_sel_rt_i,
    output logic                      id_valid_o,
    output logic [31:0]               id_instr_o,
    output logic [ADDR_W-1:0]         id_pc_o,
    output logic [REG_AW-1:0]         rs_addr_o,
    output logic [REG_AW-1:0]         rt_addr_o,
    output logic [DATA_W-1:0]         rs_data_o,
    output logic [DATA_W-1:0]         rt_data_o,
    output logic                      redirect_o,
    output logic [ADDR_W-1:0]         redirect_pc_o,
    output logic [ADDR_W-1:0]         link_pc_o
);
    localparam int NREG = 2 ** REG_AW;

    logic                valid_q, valid_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   regs_q [NREG];

    logic [REG_AW-1:0]   rs_addr, rt_addr;
    logic [DATA_W-1:0]   rs_rf, rt_rf, rs_fwd, rt_fwd;
    logic [5:0]          opcode, func;
    logic [ADDR_W-1:0]   pc_plus4, br_target, j_target, target;
    logic                taken, squash;

    assign rs_addr = instr_q[25:21];
    assign rt_addr = instr_q[20:16];
    assign opcode  = instr_q[31:26];
    assign func    = instr_q[5:0];

    // Register read with write-through bypass; r0 is never bypassed.
    always_comb begin
        rs_rf = regs_q[rs_addr];
        rt_rf = regs_q[rt_addr];
        if (wb_we_i && wb_addr_i == rs_addr) rs_rf = wb_data_i;
        if (wb_we_i && wb_addr_i == rt_addr) rt_rf = wb_data_i;
        if (rs_addr == '0) rs_rf = '0;
        if (rt_addr == '0) rt_rf = '0;
    end

    // Out-of-range selects fall back to the regfile value.
    always_comb begin
        rs_fwd = rs_rf;
        rt_fwd = rt_rf;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwd_sel_rs_i == FSEL_W'(k)) rs_fwd = fwd_data_i[(k-1)*DATA_W +: DATA_W];
            if (fwd_sel_rt_i == FSEL_W'(k)) rt_fwd = fwd_data_i[(k-1)*DATA_W +: DATA_W];
        end
    end

    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign br_target = pc_plus4 + {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
    assign j_target  = (pc_plus4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({instr_q[25:0], 2'b00});

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (opcode)
            6'h00: begin
                taken  = (func == 6'h08);
                target = ADDR_W'(rs_fwd);
            end
            6'h01: begin
                if (rt_addr == REG_AW'(0)) taken = $signed(rs_fwd) < 0;
                else if (rt_addr == REG_AW'(1)) taken = $signed(rs_fwd) >= 0;
            end
            6'h02, 6'h03: begin
                taken  = 1'b1;
                target = j_target;
            end
            6'h04: taken = (rs_fwd == rt_fwd);
            6'h05: taken = (rs_fwd != rt_fwd);
            6'h06: taken = $signed(rs_fwd) <= 0;
            6'h07: taken = $signed(rs_fwd) > 0;
            default: taken = 1'b0;
        endcase
    end

    assign redirect_o    = valid_q & ~stall_i & taken;
    assign redirect_pc_o = redirect_o ? target : '0;

`ifdef DECODE_DELAY_SLOT_EN
    assign squash    = 1'b0;
    assign link_pc_o = valid_q ? pc_q + ADDR_W'(8) : '0;
`else
    assign squash    = redirect_o;
    assign link_pc_o = valid_q ? pc_plus4 : '0;
`endif

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!stall_i) begin
            valid_d = fetch_if.valid & ~squash;
            instr_d = fetch_if.instr;
            pc_d    = fetch_if.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            if (wb_we_i && wb_addr_i != '0) regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    assign id_valid_o           = valid_q;
    assign id_instr_o           = instr_q;
    assign id_pc_o              = pc_q;
    assign rs_addr_o            = rs_addr;
    assign rt_addr_o            = rt_addr;
    assign rs_data_o            = rs_fwd;
    assign rt_data_o            = rt_fwd;
    assign fetch_if.redirect    = redirect_o;
    assign fetch_if.redirect_pc = redirect_pc_o;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic [63:0] fwd_data_i;
    logic [1:0]  fwd_sel_rs_i, fwd_sel_rt_i;
    logic        id_valid_o, redirect_o;
    logic [31:0] id_instr_o, id_pc_o, rs_data_o, rt_data_o, redirect_pc_o, link_pc_o;
    logic [4:0]  rs_addr_o, rt_addr_o;
    int          n_checks = 0;
    int          n_fail   = 0;

    decode_stage_if #(.ADDR_W(32)) fif ();

    decode_stage dut (
        .clk(clk), .rst(rst), .fetch_if(fif.slave),
        .stall_i(stall_i), .flush_i(flush_i),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .fwd_data_i(fwd_data_i), .fwd_sel_rs_i(fwd_sel_rs_i), .fwd_sel_rt_i(fwd_sel_rt_i),
        .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .link_pc_o(link_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we_i = 1'b1; wb_addr_i = a; wb_data_i = d;
        step();
        wb_we_i = 1'b0;
    endtask

    // Present one valid instruction for one edge, then leave the bus idle.
    task automatic load(input logic [31:0] ins, input logic [31:0] pc);
        fif.valid = 1'b1; fif.instr = ins; fif.pc = pc;
        step();
        fif.valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; stall_i = 0; flush_i = 0; wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;
        fwd_data_i = '0; fwd_sel_rs_i = 0; fwd_sel_rt_i = 0;
        fif.valid = 0; fif.instr = 0; fif.pc = 0;
        step();
        rst = 1'b1;

        // Reset clears IF/ID and the register file
        wr(5'd5, 32'h55);
        load(32'h00A0_0020, 32'h40);
        check("r5_before_reset", rs_data_o, 32'h55);
        rst = 1'b0; fif.valid = 1'b1;
        step();
        rst = 1'b1; fif.valid = 1'b0;
        #1;
        check("rst_valid", {31'b0, id_valid_o}, 32'h0);
        check("rst_instr", id_instr_o, 32'h0);
        check("rst_pc", id_pc_o, 32'h0);
        check("rst_redirect", {31'b0, redirect_o}, 32'h0);
        check("rst_redirect_pc", redirect_pc_o, 32'h0);
        check("rst_link", link_pc_o, 32'h0);
        check("rst_rs_data", rs_data_o, 32'h0);
        check("rst_rt_data", rt_data_o, 32'h0);
        step();
        check("rst_rs_addr5", {27'b0, rs_addr_o}, 32'd5);
        check("rst_r5_cleared", rs_data_o, 32'h0);

        // Write-through bypass, then the committed value, then r0 immunity
        load(32'h0060_0020, 32'h80);
        wb_we_i = 1; wb_addr_i = 5'd3; wb_data_i = 32'hCAFE;
        #1;
        check("bypass_same_cycle", rs_data_o, 32'hCAFE);
        step();
        wb_we_i = 0;
        #1;
        check("regfile_after_write", rs_data_o, 32'hCAFE);
        load(32'h0000_0020, 32'h84);
        wb_we_i = 1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF;
        #1;
        check("r0_no_bypass", rs_data_o, 32'h0);
        step();
        wb_we_i = 0;
        #1;
        check("r0_reads_zero", rs_data_o, 32'h0);

        // beq r1,r2 with rt forwarded from source 1
        wr(5'd1, 32'h1234);
        fwd_data_i = {32'h1234, 32'h0};
        load(32'h1022_0010, 32'h200);
        fwd_sel_rt_i = 2'd2;
        #1;
        check("fwd_rt_data", rt_data_o, 32'h1234);
        check("beq_fwd_redirect", {31'b0, redirect_o}, 32'h1);
        check("beq_fwd_target", redirect_pc_o, 32'h244);
        fwd_sel_rt_i = 2'd3;
        #1;
        check("fwd_sel_oob_rt", rt_data_o, 32'h0);
        check("beq_oob_no_redirect", {31'b0, redirect_o}, 32'h0);
        check("beq_oob_redirect_pc", redirect_pc_o, 32'h0);
        fwd_sel_rt_i = 2'd1;
        #1;
        check("fwd_src0", rt_data_o, 32'h0);
        fwd_sel_rt_i = 2'd0;
        step();

        // bne held under stall for three cycles, then one pulse
        load(32'h1420_FFFF, 32'h300);
        stall_i = 1;
        #1;
        check("stall_c0_redirect", {31'b0, redirect_o}, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("stall_c%0d_redirect", i), {31'b0, redirect_o}, 32'h0);
            check($sformatf("stall_c%0d_valid", i), {31'b0, id_valid_o}, 32'h1);
        end
        stall_i = 0;
        #1;
        check("stall_release_redirect", {31'b0, redirect_o}, 32'h1);
        check("stall_release_target", redirect_pc_o, 32'h300);
        step();
        check("stall_single_pulse", {31'b0, redirect_o}, 32'h0);

        // jal at 0x100 followed by a valid wrong-path/delay-slot instruction
        load(32'h0C00_0040, 32'h100);
        fif.valid = 1; fif.instr = 32'h0; fif.pc = 32'h104;
        #1;
        check("jal_redirect", {31'b0, redirect_o}, 32'h1);
        check("jal_target", redirect_pc_o, 32'h100);
`ifdef DECODE_DELAY_SLOT_EN
        check("jal_link", link_pc_o, 32'h108);
        step();
        check("jal_slot_valid", {31'b0, id_valid_o}, 32'h1);
`else
        check("jal_link", link_pc_o, 32'h104);
        step();
        check("jal_squash_valid", {31'b0, id_valid_o}, 32'h0);
`endif
        fif.valid = 0;
        step();

        // bltz/bgez on the most negative value, and jr through the same register
        wr(5'd4, 32'h8000_0000);
        load(32'h0480_0008, 32'h400);
        check("bltz_taken", {31'b0, redirect_o}, 32'h1);
        check("bltz_target", redirect_pc_o, 32'h424);
        step();
        load(32'h0481_0008, 32'h400);
        check("bgez_not_taken", {31'b0, redirect_o}, 32'h0);
        load(32'h0080_0008, 32'h410);
        check("jr_taken", {31'b0, redirect_o}, 32'h1);
        check("jr_target", redirect_pc_o, 32'h8000_0000);
        step();

        // blez on r0 taken with flush in the same cycle; bgtz on r0 not taken
        load(32'h1800_0004, 32'h500);
        fif.valid = 1; flush_i = 1;
        #1;
        check("blez_flush_redirect", {31'b0, redirect_o}, 32'h1);
        check("blez_target", redirect_pc_o, 32'h514);
        step();
        fif.valid = 0; flush_i = 0;
        #1;
        check("flush_redirect_valid", {31'b0, id_valid_o}, 32'h0);
        load(32'h1C00_0004, 32'h520);
        check("bgtz_not_taken", {31'b0, redirect_o}, 32'h0);
        check("nontaken_valid", {31'b0, id_valid_o}, 32'h1);

        // flush beats stall
        load(32'h0000_0020, 32'h600);
        check("pre_flush_valid", {31'b0, id_valid_o}, 32'h1);
        flush_i = 1; stall_i = 1;
        step();
        flush_i = 0; stall_i = 0;
        #1;
        check("flush_stall_valid", {31'b0, id_valid_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
